// File: rtl/trigger_link_framer_if.sv
// Sampled BX inputs and per-link TX outputs of the trigger link framer.
// master drives the BX inputs, slave is the framer itself.
interface trigger_link_framer_if #(
    parameter int NUM_LINKS         = 4,
    parameter int CLUSTERS_PER_LINK = 4,
    parameter int CLUSTER_BITS      = 14,
    parameter int ERR_CNT_BITS      = 8
);
    localparam int NCL = NUM_LINKS * CLUSTERS_PER_LINK;

    logic                          bx_strobe_i;
    logic [NCL*CLUSTER_BITS-1:0]   clusters_i;
    logic                          overflow_i;
    logic                          ttc_bx0_i;
    logic [NUM_LINKS-1:0]          link_en_i;
    logic                          test_pat_i;
    logic [16*NUM_LINKS-1:0]       tx_data_o;
    logic [2*NUM_LINKS-1:0]        tx_isk_o;
    logic                          frame_start_o;
    logic [NCL-1:0]                valid_clusters_o;
    logic                          valid_or_o;
    logic                          misalign_o;
    logic [ERR_CNT_BITS-1:0]       sync_err_cnt_o;

    modport master (
        output bx_strobe_i, clusters_i, overflow_i, ttc_bx0_i,
        output link_en_i, test_pat_i,
        input  tx_data_o, tx_isk_o, frame_start_o, valid_clusters_o,
        input  valid_or_o, misalign_o, sync_err_cnt_o
    );

    modport slave (
        input  bx_strobe_i, clusters_i, overflow_i, ttc_bx0_i,
        input  link_en_i, test_pat_i,
        output tx_data_o, tx_isk_o, frame_start_o, valid_clusters_o,
        output valid_or_o, misalign_o, sync_err_cnt_o
    );
endinterface

// File: rtl/trigger_link_framer.sv
// Per-BX framer for the trigger TX links: K-char header plus packed clusters,
// bx-strobe alignment FSM, per-link enable, counter test pattern, sync-error counter.
module trigger_link_framer #(
    parameter int NUM_LINKS         = 4,
    parameter int CLUSTERS_PER_LINK = 4,
    parameter int CLUSTER_BITS      = 14,
    parameter int FRAME_LEN         = 4,
    parameter int ERR_CNT_BITS      = 8
) (
    input  logic                  clk_160,
    input  logic                  reset_n,
    trigger_link_framer_if.slave  link
);
    localparam int LINK_BITS = CLUSTERS_PER_LINK * CLUSTER_BITS;
    localparam int PAY_BITS  = 16 * FRAME_LEN - 8;
    localparam int NREP      = (PAY_BITS + 15) / 16;
    localparam int NCL       = NUM_LINKS * CLUSTERS_PER_LINK;
    localparam int PH_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [PH_W-1:0] LAST_PH   = PH_W'(FRAME_LEN - 1);
    localparam logic [15:0]     IDLE_WORD = 16'h50BC;

    typedef enum logic {IDLE, RUN} state_t;
    // Whole frame of one link: word k is bits [16k +: 16], K-char in word 0 LSBs.
    typedef logic [FRAME_LEN-1:0][15:0] frame_t;

    state_t                          state_q, state_d;
    logic [PH_W-1:0]                 phase_q, phase_d;
    logic                            start, mis, lost;

    frame_t [NUM_LINKS-1:0]          frame_q, frame_d, new_frame;
    logic [NUM_LINKS-1:0][PAY_BITS-1:0] new_pay;
    logic [NUM_LINKS-1:0]            act_q, act_d;
    logic [NUM_LINKS-1:0][15:0]      data_q, data_d;
    logic [NUM_LINKS-1:0][1:0]       isk_q, isk_d;
    logic                            fs_q, fs_d;
    logic                            mis_q, mis_d;
    logic [NCL-1:0]                  valid_q, valid_d;
    logic                            vor_q, vor_d;
    logic [ERR_CNT_BITS-1:0]         err_q, err_d;
    logic [15:0]                     cnt_q, cnt_d;
    logic [7:0]                      kchar;
    logic [16*NREP-1:0]              rep;

    // State, captured frame and registered outputs.
    always_ff @(posedge clk_160 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            frame_q <= '0;
            act_q   <= '0;
            data_q  <= {NUM_LINKS{IDLE_WORD}};
            isk_q   <= {NUM_LINKS{2'b01}};
            fs_q    <= 1'b0;
            mis_q   <= 1'b0;
            valid_q <= '0;
            vor_q   <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            frame_q <= frame_d;
            act_q   <= act_d;
            data_q  <= data_d;
            isk_q   <= isk_d;
            fs_q    <= fs_d;
            mis_q   <= mis_d;
            valid_q <= valid_d;
            vor_q   <= vor_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Alignment FSM: phase_q is the phase of the word currently on the link.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        start   = 1'b0;
        mis     = 1'b0;
        lost    = 1'b0;
        if (link.bx_strobe_i) begin
            start   = 1'b1;
            mis     = (state_q == RUN) && (phase_q != LAST_PH);
            state_d = RUN;
            phase_d = '0;
        end else if (state_q == RUN) begin
            if (phase_q == LAST_PH) begin
                lost    = 1'b1;
                state_d = IDLE;
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    // Frame capture, counters and per-link TX word selection.
    always_comb begin
        unique case ({link.ttc_bx0_i, link.overflow_i})
            2'b11:   kchar = 8'hFC;
            2'b10:   kchar = 8'h7C;
            2'b01:   kchar = 8'h3C;
            default: kchar = 8'hBC;
        endcase
        rep = {NREP{cnt_q}};

        frame_d = frame_q;
        act_d   = act_q;
        data_d  = {NUM_LINKS{IDLE_WORD}};
        isk_d   = {NUM_LINKS{2'b01}};
        for (int l = 0; l < NUM_LINKS; l++) begin
            new_pay[l] = link.test_pat_i ? rep[PAY_BITS-1:0]
                       : PAY_BITS'(link.clusters_i[l*LINK_BITS +: LINK_BITS]);
            new_frame[l] = {new_pay[l], kchar};
            if (start) frame_d[l] = new_frame[l];
            // A re-enabled link waits for the next header before sending.
            act_d[l] = link.link_en_i[l] & (start | act_q[l]);
            if (state_d == RUN && act_d[l]) begin
                data_d[l] = start ? new_frame[l][0] : frame_q[l][phase_d];
                isk_d[l]  = (phase_d == '0) ? 2'b01 : 2'b00;
            end
        end

        valid_d = valid_q;
        for (int c = 0; c < NCL; c++) begin
            if (start)
                valid_d[c] = link.clusters_i[c*CLUSTER_BITS+9 +: 2] != 2'b11;
        end
        vor_d = |valid_d;

        fs_d  = start;
        mis_d = mis;
        cnt_d = start ? cnt_q + 16'd1 : cnt_q;
        err_d = err_q;
        if ((mis || lost) && err_q != '1) err_d = err_q + 1'b1;
    end

    assign link.tx_data_o        = data_q;
    assign link.tx_isk_o         = isk_q;
    assign link.frame_start_o    = fs_q;
    assign link.misalign_o       = mis_q;
    assign link.valid_clusters_o = valid_q;
    assign link.valid_or_o       = vor_q;
    assign link.sync_err_cnt_o   = err_q;
endmodule
